sprite_line_scheduler: RTL

- Per-scanline sprite fetch controller for the Frogger VGA path. It replaces per-pixel on-the-fly sprite lookup.
- During each line it walks the frog slot and the four car slots for the next line. It sequences reads of the shared frog/car sprite ROMs (1-cycle latency Memory modules) and writes non-transparent pixels into a double-banked 640-entry line buffer.
- The pixel output stage reads the other bank.

---
 rtl/sprite_line_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite fetch controller: walks frog + four car slots, reads sprite ROMs, fills a line-buffer bank.
// Optional: define SPRITE_SCHED_FROG_TOP_EN to fetch the frog last so it is drawn over the cars.
module sprite_line_scheduler #(
  parameter int         TILE_SIZE      = 32,
  parameter int         H_VISIBLE_AREA = 640,
  parameter int         V_VISIBLE_AREA = 480,
  parameter logic [8:0] LANE_1_Y       = 9'd96,
  parameter logic [8:0] LANE_2_Y       = 9'd160,
  parameter logic [8:0] LANE_3_Y       = 9'd224,
  parameter logic [8:0] LANE_4_Y       = 9'd288
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Line_Start,
  input  logic [9:0] i_Line,
  input  logic [9:0] i_Frog_X,
  input  logic [8:0] i_Frog_Y,
  input  logic [1:0] i_Frog_Direction,
  input  logic [9:0] i_Car_1X_Position,
  input  logic [9:0] i_Car_2X_Position,
  input  logic [9:0] i_Car_3X_Position,
  input  logic [9:0] i_Car_4X_Position,
  input  logic [3:0] i_Reverse,
  output logic       o_Rom_Rd_En,
  output logic       o_Rom_Sel,
  output logic [9:0] o_Rom_Addr,
  input  logic [8:0] i_Rom_Data,
  output logic       o_Lb_Wr_En,
  output logic       o_Lb_Bank,
  output logic [9:0] o_Lb_Wr_Addr,
  output logic [8:0] o_Lb_Wr_Data,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Overrun
);
  localparam int            TW       = $clog2(TILE_SIZE);
  localparam logic [TW-1:0] LAST_COL = TW'(TILE_SIZE - 1);
  localparam logic [35:0]   LANE_Y   = {LANE_4_Y, LANE_3_Y, LANE_2_Y, LANE_1_Y};

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, DRAIN, DONE} state_t;

  state_t        state_reg;
  logic [2:0]    slot_reg;
  logic [TW-1:0] row_reg, col_reg;
  logic [9:0]    line_reg, frog_x_reg;
  logic [8:0]    frog_y_reg;
  logic [1:0]    dir_reg;
  logic [3:0]    rev_reg;
  logic [9:0]    car_x_reg [4];
  logic [9:0]    car_x_in [4];
  logic [9:0]    sprite_x [5];
  logic [8:0]    sprite_y [5];
  logic          bank_reg, done_reg, overrun_reg;
  logic          rd_en_reg, sel_reg, wr_pend_reg;
  logic [9:0]    addr_reg;
  logic [10:0]   rd_x_reg, wr_x_reg;

  assign car_x_in[0] = i_Car_1X_Position;
  assign car_x_in[1] = i_Car_2X_Position;
  assign car_x_in[2] = i_Car_3X_Position;
  assign car_x_in[3] = i_Car_4X_Position;
  assign sprite_x[0] = frog_x_reg;
  assign sprite_y[0] = frog_y_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_car
      assign sprite_x[gi+1] = car_x_reg[gi];
      assign sprite_y[gi+1] = LANE_Y[gi*9 +: 9];
    end
  endgenerate

  // Slot walk order -> sprite id (0 = frog, 1..4 = cars); later slots overwrite earlier ones.
  function automatic logic [2:0] sprite_of(input logic [2:0] s);
`ifdef SPRITE_SCHED_FROG_TOP_EN
    return (s == 3'd4) ? 3'd0 : s + 3'd1;
`else
    return s;
`endif
  endfunction

  // With T a power of two, T-1-n is the bitwise inverse of n and hi*T+lo is a concatenation.
  function automatic logic [9:0] rom_addr(input logic car, input logic rev, input logic [1:0] dir,
                                          input logic [TW-1:0] r, input logic [TW-1:0] c);
    logic [TW-1:0] hi, lo;
    hi = r;
    lo = c;
    if (car) begin
      lo = rev ? c : ~c;
    end else begin
      case (dir)
        2'd0:    begin hi = r;  lo = c; end
        2'd1:    begin hi = c;  lo = r; end
        2'd2:    begin hi = ~c; lo = r; end
        default: begin hi = ~r; lo = c; end
      endcase
    end
    return 10'({hi, lo});
  endfunction

  logic [2:0]    cur_id;
  logic [9:0]    cur_x;
  logic [8:0]    cur_y;
  logic          is_car, car_rev, hit, last_slot;
  logic [10:0]   y_end;
  logic [TW-1:0] row_new, col_next;

  always_comb begin
    cur_id    = sprite_of(slot_reg);
    cur_x     = sprite_x[cur_id];
    cur_y     = sprite_y[cur_id];
    is_car    = (cur_id != 3'd0);
    car_rev   = rev_reg[2'(cur_id - 3'd1)];
    y_end     = {2'b00, cur_y} + 11'(TILE_SIZE);
    hit       = ({1'b0, line_reg} < 11'(V_VISIBLE_AREA)) &&
                ({1'b0, line_reg} >= {2'b00, cur_y}) && ({1'b0, line_reg} < y_end);
    row_new   = TW'({1'b0, line_reg} - {2'b00, cur_y});
    col_next  = col_reg + 1'b1;
    last_slot = (slot_reg == 3'd4);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg   <= IDLE;
      slot_reg    <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      line_reg    <= '0;
      frog_x_reg  <= '0;
      frog_y_reg  <= '0;
      dir_reg     <= '0;
      rev_reg     <= '0;
      for (int i = 0; i < 4; i++) car_x_reg[i] <= '0;
      bank_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      rd_en_reg   <= 1'b0;
      sel_reg     <= 1'b0;
      addr_reg    <= '0;
      rd_x_reg    <= '0;
      wr_x_reg    <= '0;
      wr_pend_reg <= 1'b0;
    end else begin
      // ROM data arrives one cycle after the read, so the write decision trails the read by one.
      done_reg    <= 1'b0;
      rd_en_reg   <= 1'b0;
      wr_pend_reg <= rd_en_reg;
      wr_x_reg    <= rd_x_reg;
      if (i_Line_Start) begin
        if (state_reg != IDLE) begin
          overrun_reg <= 1'b1;
          wr_pend_reg <= 1'b0;
        end
        line_reg   <= i_Line;
        frog_x_reg <= i_Frog_X;
        frog_y_reg <= i_Frog_Y;
        dir_reg    <= i_Frog_Direction;
        rev_reg    <= i_Reverse;
        for (int i = 0; i < 4; i++) car_x_reg[i] <= car_x_in[i];
        bank_reg   <= ~bank_reg;
        slot_reg   <= '0;
        state_reg  <= CHECK;
      end else begin
        case (state_reg)
          CHECK: begin
            if (hit) begin
              row_reg   <= row_new;
              col_reg   <= '0;
              rd_en_reg <= 1'b1;
              sel_reg   <= is_car;
              addr_reg  <= rom_addr(is_car, car_rev, dir_reg, row_new, '0);
              rd_x_reg  <= {1'b0, cur_x};
              state_reg <= FETCH;
            end else if (last_slot) begin
              state_reg <= DONE;
            end else begin
              slot_reg  <= slot_reg + 3'd1;
            end
          end
          FETCH: begin
            if (col_reg == LAST_COL) begin
              state_reg <= DRAIN;
            end else begin
              col_reg   <= col_next;
              rd_en_reg <= 1'b1;
              addr_reg  <= rom_addr(is_car, car_rev, dir_reg, row_reg, col_next);
              rd_x_reg  <= {1'b0, cur_x} + 11'(col_next);
            end
          end
          DRAIN: begin
            if (last_slot) begin
              state_reg <= DONE;
            end else begin
              slot_reg  <= slot_reg + 3'd1;
              state_reg <= CHECK;
            end
          end
          DONE: begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign o_Rom_Rd_En  = rd_en_reg;
  assign o_Rom_Sel    = sel_reg;
  assign o_Rom_Addr   = addr_reg;
  assign o_Lb_Wr_En   = wr_pend_reg && (wr_x_reg < 11'(H_VISIBLE_AREA)) && (i_Rom_Data != 9'h000);
  assign o_Lb_Wr_Addr = o_Lb_Wr_En ? wr_x_reg[9:0] : 10'd0;
  assign o_Lb_Wr_Data = o_Lb_Wr_En ? i_Rom_Data : 9'h000;
  assign o_Lb_Bank    = bank_reg;
  assign o_Busy       = (state_reg != IDLE);
  assign o_Done       = done_reg;
  assign o_Overrun    = overrun_reg;
endmodule
